// File: rtl/mul_ctrl_pkg.sv
// Shared types for the RV64M multiply issue controller: datapath width,
// multiply opcode, controller state and the one-entry result cache entry.
package mul_ctrl_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned HALFW = XLEN / 2;

  typedef logic [XLEN-1:0] data_t;

  typedef enum logic [2:0] {
    MUL_OP_MUL    = 3'd0,
    MUL_OP_MULH   = 3'd1,
    MUL_OP_MULHSU = 3'd2,
    MUL_OP_MULHU  = 3'd3,
    MUL_OP_MULW   = 3'd4
  } mul_op_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_RESP    = 3'd4
  } mul_ctrl_state_t;

  typedef struct packed {
    logic    valid;
    mul_op_t op;
    data_t   a;
    data_t   b;
    data_t   data;
  } mul_cache_t;

  // Encodings 5..7 are illegal and execute as a plain MUL.
  function automatic mul_op_t decode_op(logic [2:0] raw);
    return (raw > 3'd4) ? MUL_OP_MUL : mul_op_t'(raw);
  endfunction

endpackage

// File: rtl/mul_ctrl.sv
// mul_ctrl: issue/handshake controller in front of the `mul` multiplier.
// Accepts RV64M multiply requests, derives operand forms and sign/half
// controls, drives mul's one-shot start/ready protocol, returns the result
// on a valid/ready channel and keeps a one-entry result cache.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   kill pending/in-flight operation
//   req_valid/req_ready     request handshake; req_op/req_a/req_b payload
//   resp_valid/resp_ready   response handshake; resp_data = final rd value
//   mul_a/mul_b, mul_sign1/mul_sign2/mul_get_hi, mul_start   drive `mul`
//   mul_ready/mul_result    `mul` completion and result
module mul_ctrl
  import mul_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [XLEN-1:0] mul_a,
  output logic [XLEN-1:0] mul_b,
  output logic            mul_sign1,
  output logic            mul_sign2,
  output logic            mul_get_hi,
  output logic            mul_start,
  input  logic            mul_ready,
  input  logic [XLEN-1:0] mul_result
);

  mul_ctrl_state_t r_state;
  mul_cache_t      r_cache;
  mul_op_t         r_op;
  data_t           r_a;
  data_t           r_b;
  data_t           r_resp_data;
  data_t           r_mul_a;
  data_t           r_mul_b;
  logic            r_resp_valid;
  logic            r_mul_start;
  logic            r_sign1;
  logic            r_sign2;
  logic            r_get_hi;

  mul_op_t w_op;
  logic    w_fire;
  logic    w_hit;
  data_t   w_mul_a;
  data_t   w_mul_b;
  logic    w_sign1;
  logic    w_sign2;
  logic    w_get_hi;
  data_t   w_result;

  assign w_op   = decode_op(req_op);
  assign w_fire = req_valid && req_ready;
  assign w_hit  = r_cache.valid && (r_cache.op == w_op) &&
                  (r_cache.a == req_a) && (r_cache.b == req_b);

  // Acceptance is only possible from IDLE and is blocked by a same-cycle flush.
  assign req_ready = (r_state == ST_IDLE) && !flush;

  // MULW returns the sign-extended low word of the product.
  assign w_result = (r_op == MUL_OP_MULW) ?
                    {{HALFW{mul_result[HALFW-1]}}, mul_result[HALFW-1:0]} :
                    mul_result;

  // Operand forms and sign/half controls per opcode.
  always_comb begin
    w_mul_a  = req_a;
    w_mul_b  = req_b;
    w_sign1  = 1'b0;
    w_sign2  = 1'b0;
    w_get_hi = 1'b0;
    case (w_op)
      MUL_OP_MULH: begin
        w_sign1  = 1'b1;
        w_sign2  = 1'b1;
        w_get_hi = 1'b1;
      end
      MUL_OP_MULHSU: begin
        w_sign1  = 1'b1;
        w_get_hi = 1'b1;
      end
      MUL_OP_MULHU: begin
        w_get_hi = 1'b1;
      end
      MUL_OP_MULW: begin
        w_mul_a = {HALFW'(0), req_a[HALFW-1:0]};
        w_mul_b = {HALFW'(0), req_b[HALFW-1:0]};
      end
      default: ;
    endcase
  end

  // Controller FSM with registered outputs. Operand registers only change on
  // a miss fire, so they stay stable from ISSUE until CAPTURE/DRAIN is left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cache      <= '0;
      r_op         <= MUL_OP_MUL;
      r_a          <= '0;
      r_b          <= '0;
      r_resp_data  <= '0;
      r_resp_valid <= 1'b0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_sign1      <= 1'b0;
      r_sign2      <= 1'b0;
      r_get_hi     <= 1'b0;
      r_mul_start  <= 1'b0;
    end else begin
      r_mul_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            r_op <= w_op;
            r_a  <= req_a;
            r_b  <= req_b;
            if (w_hit) begin
              r_resp_data  <= r_cache.data;
              r_resp_valid <= 1'b1;
              r_state      <= ST_RESP;
            end else begin
              r_mul_a     <= w_mul_a;
              r_mul_b     <= w_mul_b;
              r_sign1     <= w_sign1;
              r_sign2     <= w_sign2;
              r_get_hi    <= w_get_hi;
              r_mul_start <= 1'b1;
              r_state     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          r_state <= flush ? ST_DRAIN : ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (mul_ready) begin
            if (flush) begin
              r_state <= ST_IDLE;
            end else begin
              r_resp_data  <= w_result;
              r_resp_valid <= 1'b1;
              r_cache      <= '{valid: 1'b1, op: r_op, a: r_a, b: r_b, data: w_result};
              r_state      <= ST_RESP;
            end
          end else if (flush) begin
            r_state <= ST_DRAIN;
          end
        end
        // mul is outside this reset/flush domain: wait out its ready pulse.
        ST_DRAIN: begin
          if (mul_ready) begin
            r_state <= ST_IDLE;
          end
        end
        ST_RESP: begin
          if (resp_ready || flush) begin
            r_resp_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign mul_a      = r_mul_a;
  assign mul_b      = r_mul_b;
  assign mul_sign1  = r_sign1;
  assign mul_sign2  = r_sign2;
  assign mul_get_hi = r_get_hi;
  assign mul_start  = r_mul_start;

endmodule

// File: doc/mul_ctrl.md
# mul_ctrl

Issue/handshake controller that sits directly upstream of the `mul` multiplier in the execute stage. It accepts RV64M multiply requests from the EX pipeline, derives operand forms and sign/half controls, and drives `mul` through its one-shot `start`/`ready` protocol. It captures and returns the result on a valid/ready response channel, with a one-entry result cache and flush handling. `mul` is not reset by this block's reset domain, so every issued start is drained before the controller goes idle.

## Interface
- XLEN, 64, datapath width (from `def_cpu.svh`)
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  kill in-flight/pending operation
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when also req_valid
- req_op  in  3  mul_op_t: MUL=0, MULH=1, MULHSU=2, MULHU=3, MULW=4 (5–7 illegal, treated as MUL)
- req_a, req_b  in  XLEN  rs1/rs2 values
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_data  out  XLEN  final rd value
- mul_a, mul_b  out  XLEN  operands to `mul`, held stable from ISSUE through CAPTURE
- mul_sign1, mul_sign2, mul_get_hi  out  1  sign/half controls to `mul`
- mul_start  out  1  start pulse to `mul`
- mul_ready  in  1  `mul` ready
- mul_result  in  XLEN  `mul` result_o, valid only while mul_ready=1

## Operation
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_data=0, mul_start=0, mul_a/mul_b=0, control outputs 0, cache valid=0.
- States: IDLE, ISSUE, CAPTURE, DRAIN, RESP.
- IDLE: req_ready = !flush. On fire, latch op/a/b. If cache valid and (op,a,b) matches, load resp_data from cache and go to RESP. Otherwise go to ISSUE.
- ISSUE: mul_start=1 for exactly this cycle. Next state is CAPTURE, or DRAIN if flush.
- CAPTURE: wait for mul_ready=1. On that cycle: write result to resp_data and cache (op,a,b,data); cache valid=1; go to RESP. If flush is also high, discard the result, leave the cache untouched, and go to IDLE. While mul_ready=0, stay in CAPTURE; a flush in that case goes to DRAIN.
- DRAIN: wait for mul_ready=1, discard the result, then go to IDLE.
- RESP: resp_valid=1, data held stable until resp_ready. resp_ready or flush leads to IDLE.
- req_ready=0 in every state except IDLE.
- Operand forms:
  - MUL: sign1=sign2=0, get_hi=0.
  - MULH: 1/1, hi.
  - MULHSU: 1/0, hi.
  - MULHU: 0/0, hi.
  - MULW: mul_a/mul_b = zero-extended low 32 bits, signs 0, get_hi=0. Result = sign-extension of mul_result[31:0].
- Cache key includes op, so MULH followed by MUL on the same operands is a miss. A flush never invalidates the cache.

## Timing
- Miss latency: fire at cycle n, ISSUE n+1, CAPTURE n+2, resp_valid n+3. Back-to-back throughput is one result per 4 cycles when resp_ready=1.
- Hit latency: fire at n, resp_valid n+1.
- mul_a/mul_b/sign/get_hi are registered and must not change from ISSUE until leaving CAPTURE/DRAIN. `mul` derives its result combinationally from them.
- A flush in the same cycle as req_valid blocks acceptance.
- Asynchronous reset mid-operation returns to IDLE immediately. If `mul` is still mid-cycle, its one ready pulse arrives in IDLE and is ignored.

## Structure
- Add `mul_op_t` enum and `mul_ctrl_state_t` to the shared CPU package alongside `data_t`.
- Cache entry is a packed struct {valid, op, a, b, data} in the same package.
- No sub-modules. `mul` is instantiated by the EX stage next to this block, not inside it.

## Test plan
- MULH a=-3 (0xFFFF…FFFD), b=5 → mul_start at n+1 with sign1=sign2=1, get_hi=1; resp_data=0xFFFF_FFFF_FFFF_FFFF at n+3.
- MULW a=0x0000_0001_8000_0000, b=2 → mul_a=0x8000_0000, resp_data=0x0000_0000_0000_0000; then a=0x4000_0000, b=2 → 0xFFFF_FFFF_8000_0000.
- Repeat MULHU 0xFFFF…FFFF×0xFFFF…FFFF twice → first resp_data=0xFFFF…FFFE at n+3; second at n+1 with no mul_start. MUL with the same operands → miss, result 1.
- Flush during ISSUE → no resp_valid; controller waits for mul_ready in DRAIN, then req_ready=1. The cache still holds the prior entry.
- RESP with resp_ready=0 for 5 cycles → resp_valid and resp_data stable, req_ready=0 throughout.
- rst_n low during CAPTURE → outputs reset asynchronously. The next MUL 7×6 returns 42 correctly.
